// File: rtl/cpu_axi_pkg.sv
// Shared encodings for the CPU-to-AXI bridge: FSM states, AXI size codes and read IDs.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [2:0] AXI_SIZE_DWORD = 3'd3;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // CPU size codes map one-to-one onto the low AXI size codes.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    logic [2:0] code;
    case (size)
      2'd0:    code = AXI_SIZE_BYTE;
      2'd1:    code = AXI_SIZE_HALF;
      2'd2:    code = AXI_SIZE_WORD;
      default: code = AXI_SIZE_DWORD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU inst/data SRAM-like ports onto a single-beat AXI master with
// one outstanding read and one outstanding write.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID_INST = ID_INST,
  parameter logic [3:0] RD_ID_DATA = ID_DATA
) (
  input  logic        clock,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   r_state_q, r_state_d;
  wr_state_e   w_state_q, w_state_d;
  logic        run_q;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic data_rd_req, data_wr_req;
  logic inst_clear, data_clear, rd_free;
  logic inst_acc, data_rd_acc, data_wr_acc;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic unused_resp;

  assign unused_resp = ^{rresp, bresp};

  assign data_rd_req = data_req && !data_wr;
  assign data_wr_req = data_req && data_wr;

  // A read may not overtake a pending write to the same word.
  assign inst_clear = (w_state_q == W_IDLE) || (aw_addr_q[31:2] != inst_addr[31:2]);
  assign data_clear = (w_state_q == W_IDLE) || (aw_addr_q[31:2] != data_addr[31:2]);
  assign rd_free    = run_q && (r_state_q == R_IDLE);

  assign data_rd_acc = rd_free && data_rd_req && data_clear;
  assign inst_acc    = rd_free && inst_req && !data_rd_req && inst_clear;
  assign data_wr_acc = run_q && data_wr_req && (w_state_q == W_IDLE);

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = data_rd_acc || data_wr_acc;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = run_q;

  assign awaddr  = aw_addr_q;
  assign awsize  = aw_size_q;
  assign awvalid = (w_state_q == W_REQ) && !aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = (w_state_q == W_REQ) && !w_done_q;
  assign bready  = run_q;

  assign ar_hs = arvalid && arready;
  assign r_hs  = (r_state_q == R_DATA) && rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = (w_state_q == W_RESP) && bvalid && bready;

  assign inst_data_ok = r_hs && (rid == RD_ID_INST);
  assign data_data_ok = (r_hs && (rid == RD_ID_DATA)) || b_hs;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    ar_size_d = ar_size_q;
    ar_id_d   = ar_id_q;
    case (r_state_q)
      R_IDLE: begin
        if (data_rd_acc) begin
          ar_addr_d = data_addr;
          ar_size_d = axi_size(data_size);
          ar_id_d   = RD_ID_DATA;
          r_state_d = R_AR;
        end else if (inst_acc) begin
          ar_addr_d = inst_addr;
          ar_size_d = axi_size(inst_size);
          ar_id_d   = RD_ID_INST;
          r_state_d = R_AR;
        end
      end
      R_AR:    if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_size_d = aw_size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: begin
        if (data_wr_acc) begin
          aw_addr_d = data_addr;
          aw_size_d = axi_size(data_size);
          wdata_d   = data_wdata;
          wstrb_d   = data_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W complete independently; move on once both have landed.
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_q     <= 1'b0;
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      ar_id_q   <= '0;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      ar_addr_q <= ar_addr_d;
      ar_size_q <= ar_size_d;
      ar_id_q   <= ar_id_d;
      aw_addr_q <= aw_addr_d;
      aw_size_q <= aw_size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Scoreboard bench for cpu_axi_bridge: directed CPU requests against a reactive AXI slave.
module tb_cpu_axi_bridge;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [1:0]  inst_size = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;

  always #5 clock = ~clock;

  cpu_axi_bridge dut (
    .clock(clock), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct { logic [31:0] data; int cyc; } inst_exp_t;
  typedef struct { logic is_wr; logic [31:0] data; } data_exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] id; logic [2:0] size; } ar_exp_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; } aw_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;

  inst_exp_t inst_q[$];
  data_exp_t data_q[$];
  ar_exp_t   ar_q[$];
  aw_exp_t   aw_q[$];
  w_exp_t    w_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int b_cyc = -1;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: got=%h (cycle %0d)", name, act, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Reactive AXI slave: drives its outputs just after each rising edge.
  // Read data is the address XOR 0x5A5A5A5A.
  logic [31:0] pend_addr = '0;
  logic [3:0]  pend_id = '0;
  bit rd_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  int r_cnt = 0, b_cnt = 0;

  always @(posedge clock) begin
    #1;
    if (!resetn) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    end else begin
      rvalid = 0;
      if (rd_pend) begin
        if (r_cnt > 0) r_cnt--;
        else begin
          rvalid = 1; rid = pend_id; rdata = pend_addr ^ 32'h5A5A5A5A; rd_pend = 0;
        end
      end
      arready = 0;
      if (arvalid) begin
        if (ar_wait > 0) ar_wait--;
        else begin
          arready = 1; rd_pend = 1; pend_addr = araddr; pend_id = arid; r_cnt = r_wait;
        end
      end
      awready = 0;
      if (awvalid) begin
        if (aw_wait > 0) aw_wait--;
        else begin awready = 1; aw_got = 1; end
      end
      wready = 0;
      if (wvalid) begin
        if (w_wait > 0) w_wait--;
        else begin wready = 1; w_got = 1; end
      end
      bvalid = 0;
      if (b_pend) begin
        if (b_cnt > 0) b_cnt--;
        else begin bvalid = 1; b_pend = 0; end
      end
      if (aw_got && w_got) begin
        b_pend = 1; b_cnt = b_wait; aw_got = 0; w_got = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or response.
  inst_exp_t m_i;
  data_exp_t m_d;
  ar_exp_t   m_ar;
  aw_exp_t   m_aw;
  w_exp_t    m_w;

  always @(negedge clock) begin
    if (bvalid) b_cyc = cyc;
    if (arvalid && arready) begin
      if (ar_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ar_unexpected: araddr=%h arid=%h, none expected", araddr, arid);
      end else begin
        m_ar = ar_q.pop_front();
        check("ar_addr", araddr, m_ar.addr);
        check("ar_id", 32'(arid), 32'(m_ar.id));
        check("ar_size", 32'(arsize), 32'(m_ar.size));
      end
    end
    if (awvalid && awready) begin
      if (aw_q.size() == 0) begin
        total++; bad++;
        $display("FAIL aw_unexpected: awaddr=%h, none expected", awaddr);
      end else begin
        m_aw = aw_q.pop_front();
        check("aw_addr", awaddr, m_aw.addr);
        check("aw_size", 32'(awsize), 32'(m_aw.size));
      end
    end
    if (wvalid && wready) begin
      if (w_q.size() == 0) begin
        total++; bad++;
        $display("FAIL w_unexpected: wdata=%h, none expected", wdata);
      end else begin
        m_w = w_q.pop_front();
        check("w_data", wdata, m_w.data);
        check("w_strb", 32'(wstrb), 32'(m_w.strb));
      end
    end
    if (inst_data_ok) begin
      if (inst_q.size() == 0) begin
        total++; bad++;
        $display("FAIL inst_ok_unexpected: inst_rdata=%h, none expected", inst_rdata);
      end else begin
        m_i = inst_q.pop_front();
        check("inst_rdata", inst_rdata, m_i.data);
        if (m_i.cyc >= 0) check("inst_latency", 32'(cyc), 32'(m_i.cyc));
      end
    end
    if (data_data_ok) begin
      if (data_q.size() == 0) begin
        total++; bad++;
        $display("FAIL data_ok_unexpected: data_rdata=%h, none expected", data_rdata);
      end else begin
        m_d = data_q.pop_front();
        check("data_kind_wr", 32'(bvalid), 32'(m_d.is_wr));
        if (!m_d.is_wr) check("data_rdata", data_rdata, m_d.data);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_accept(input string name, input bit is_inst, output bit ok, output int acc);
    int n;
    n = 0;
    @(negedge clock);
    while (!(is_inst ? inst_addr_ok : data_addr_ok) && n < 100) begin
      step();
      @(negedge clock);
      n++;
    end
    ok = (n < 100);
    acc = cyc;
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s_accept: addr_ok stayed 0 for 100 cycles, want 1", name);
    end
  endtask

  task automatic inst_read(input logic [31:0] a, input logic [31:0] exp, input bit lat,
                           output int acc);
    bit ok;
    inst_req = 1; inst_addr = a; inst_size = 2'd2;
    wait_accept("inst_rd", 1'b1, ok, acc);
    if (ok) begin
      ar_q.push_back('{addr: a, id: 4'd0, size: 3'd2});
      inst_q.push_back('{data: exp, cyc: lat ? acc + 2 : -1});
    end
    step();
    inst_req = 0;
  endtask

  task automatic data_read(input logic [31:0] a, input logic [1:0] sz, input logic [2:0] exp_sz,
                           input logic [31:0] exp, output int acc);
    bit ok;
    data_req = 1; data_wr = 0; data_addr = a; data_size = sz;
    wait_accept("data_rd", 1'b0, ok, acc);
    if (ok) begin
      ar_q.push_back('{addr: a, id: 4'd1, size: exp_sz});
      data_q.push_back('{is_wr: 1'b0, data: exp});
    end
    step();
    data_req = 0;
  endtask

  task automatic data_write(input logic [31:0] a, input logic [1:0] sz, input logic [2:0] exp_sz,
                            input logic [31:0] wd, input logic [3:0] ws, output int acc);
    bit ok;
    data_req = 1; data_wr = 1; data_addr = a; data_size = sz; data_wdata = wd; data_wstrb = ws;
    wait_accept("data_wr", 1'b0, ok, acc);
    if (ok) begin
      aw_q.push_back('{addr: a, size: exp_sz});
      w_q.push_back('{data: wd, strb: ws});
      data_q.push_back('{is_wr: 1'b1, data: 32'h0});
    end
    step();
    data_req = 0; data_wr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;

    // Reset state, with a request pending that must not be acknowledged.
    inst_req = 1; inst_addr = 32'h0000_0010; inst_size = 2'd2;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    check("rst_araddr", araddr, 32'h0);
    inst_req = 0;
    step();
    resetn = 1;
    step();
    @(negedge clock);
    check("post_rst_rready", 32'(rready), 1);
    check("post_rst_bready", 32'(bready), 1);

    // Boot fetch, zero-wait slave: data_ok two cycles after acceptance.
    step();
    inst_read(32'hBFC0_0000, 32'hE59A_5A5A, 1'b1, acc);
    repeat (4) step();

    // Data read wins over a simultaneous inst read.
    data_req = 1; data_wr = 0; data_addr = 32'h0000_0200; data_size = 2'd2;
    inst_req = 1; inst_addr = 32'h0000_0100; inst_size = 2'd2;
    @(negedge clock);
    check("prio_data_addr_ok", 32'(data_addr_ok), 1);
    check("prio_inst_addr_ok", 32'(inst_addr_ok), 0);
    ar_q.push_back('{addr: 32'h0000_0200, id: 4'd1, size: 3'd2});
    data_q.push_back('{is_wr: 1'b0, data: 32'h5A5A_585A});
    step();
    data_req = 0;
    inst_read(32'h0000_0100, 32'h5A5A_5B5A, 1'b0, acc);
    repeat (6) step();

    // Read-after-write to the same word waits for the write response.
    b_wait = 4;
    data_write(32'h0000_0080, 2'd1, 3'd1, 32'hCAFE_BEEF, 4'h3, acc);
    data_req = 1; data_wr = 0; data_addr = 32'h0000_0080; data_size = 2'd2;
    @(negedge clock);
    check("raw_hold_addr_ok", 32'(data_addr_ok), 0);
    step();
    data_read(32'h0000_0080, 2'd2, 3'd2, 32'h5A5A_5ADA, acc2);
    check("raw_accept_after_b", 32'(acc2 > b_cyc && b_cyc > acc), 1);
    b_wait = 0;
    repeat (8) step();

    // AW completes three cycles ahead of W.
    w_wait = 3;
    data_write(32'h0000_0240, 2'd2, 3'd2, 32'h1122_3344, 4'hF, acc);
    @(negedge clock);
    check("split_awvalid_first", 32'(awvalid), 1);
    step();
    @(negedge clock);
    check("split_aw_dropped", 32'(awvalid), 0);
    check("split_w_held", 32'(wvalid), 1);
    repeat (10) step();

    // Data write and inst read accepted together.
    data_req = 1; data_wr = 1; data_addr = 32'h0000_0300; data_size = 2'd2;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
    inst_req = 1; inst_addr = 32'h0000_0400; inst_size = 2'd2;
    @(negedge clock);
    check("dual_data_addr_ok", 32'(data_addr_ok), 1);
    check("dual_inst_addr_ok", 32'(inst_addr_ok), 1);
    aw_q.push_back('{addr: 32'h0000_0300, size: 3'd2});
    w_q.push_back('{data: 32'hDEAD_BEEF, strb: 4'hF});
    data_q.push_back('{is_wr: 1'b1, data: 32'h0});
    ar_q.push_back('{addr: 32'h0000_0400, id: 4'd0, size: 3'd2});
    inst_q.push_back('{data: 32'h5A5A_5E5A, cyc: -1});
    step();
    data_req = 0; data_wr = 0; inst_req = 0;
    repeat (8) step();

    // arready held low for five cycles: AR payload must not move.
    ar_wait = 5;
    data_read(32'h0000_1234, 2'd0, 3'd0, 32'h5A5A_486E, acc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_arvalid", 32'(arvalid), 1);
      check("stall_araddr", araddr, 32'h0000_1234);
      check("stall_arid", 32'(arid), 1);
      check("stall_arsize", 32'(arsize), 0);
      step();
    end
    repeat (8) step();

    // Reset while waiting for read data; the read is abandoned.
    r_wait = 5;
    inst_read(32'h0000_0500, 32'h5A5A_5F5A, 1'b0, acc);
    step();
    resetn = 0;
    inst_q.delete();
    inst_req = 1; inst_addr = 32'h0000_0600; inst_size = 2'd2;
    @(negedge clock);
    check("midrst_arvalid", 32'(arvalid), 0);
    check("midrst_inst_data_ok", 32'(inst_data_ok), 0);
    check("midrst_inst_addr_ok", 32'(inst_addr_ok), 0);
    check("midrst_rready", 32'(rready), 0);
    inst_req = 0;
    step();
    step();
    resetn = 1;
    r_wait = 0;
    step();
    @(negedge clock);
    check("midrst_rready_back", 32'(rready), 1);
    step();
    inst_read(32'h0000_0600, 32'h5A5A_5C5A, 1'b1, acc);
    repeat (8) step();

    check("left_inst", 32'(inst_q.size()), 0);
    check("left_data", 32'(data_q.size()), 0);
    check("left_ar", 32'(ar_q.size()), 0);
    check("left_aw", 32'(aw_q.size()), 0);
    check("left_w", 32'(w_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have inst port: inst_req in 1; inst_addr in 32; inst_size in 2 (0=byte,1=half,2=word); inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-003 SHALL have data port: data_req in 1; data_wr in 1; data_size in 2; data_addr in 32; data_wstrb in 4; data_wdata in 32; data_addr_ok out 1; data_data_ok out 1; data_rdata out 32.
REQ-004 SHALL have AXI read master: arid out 4; araddr out 32; arsize out 3; arvalid out 1; arready in 1; rid in 4; rdata in 32; rresp in 2; rvalid in 1; rready out 1.
REQ-005 SHALL have AXI write master: awaddr out 32; awsize out 3; awvalid out 1; awready in 1; wdata out 32; wstrb out 4; wvalid out 1; wready in 1; bresp in 2; bvalid in 1; bready out 1.
REQ-006 SHALL have parameter RD_ID_INST, default 0, arid for inst reads; RD_ID_DATA, default 1, arid for data reads.

Function
REQ-007 SHALL issue single-beat transfers only; arsize/awsize = {1'b0, size}.
REQ-008 SHALL hold read FSM R_IDLE -> R_AR (arvalid=1) -> R_DATA (await rvalid) -> R_IDLE; R_AR->R_DATA on arvalid&&arready; R_DATA->R_IDLE on rvalid&&rready.
REQ-009 SHALL hold write FSM W_IDLE -> W_REQ (awvalid, wvalid) -> W_RESP -> W_IDLE; AW and W handshakes tracked independently, either order or same cycle; W_REQ->W_RESP when both done; W_RESP->W_IDLE on bvalid&&bready.
REQ-010 SHALL accept a read (addr_ok=1, combinational) only in R_IDLE and only if write FSM is W_IDLE or pending awaddr[31:2] differs from request addr[31:2].
REQ-011 SHALL accept a data write (data_addr_ok=1) only in W_IDLE.
REQ-012 SHALL give data reads priority over inst reads when both request in R_IDLE; inst_addr_ok=0 that cycle.
REQ-013 SHALL accept a data write and an inst read in the same cycle when both FSMs idle.
REQ-014 SHALL register address/size/wdata/wstrb/id on acceptance; arvalid/awvalid/wvalid high from the next cycle until handshake; AXI outputs stable while valid and not ready.
REQ-015 SHALL drive rready=1 and bready=1 constantly out of reset.
REQ-016 SHALL pulse inst_data_ok for one cycle combinationally when rvalid&&rid==RD_ID_INST, data_data_ok when rvalid&&rid==RD_ID_DATA, or on bvalid (write); inst_rdata/data_rdata = rdata.
REQ-017 SHALL ignore rresp/bresp (no error signalling).
REQ-018 SHALL give minimum latency: req accepted cycle N, arvalid cycle N+1, data_ok cycle N+2 with zero-wait slave.
REQ-019 SHALL permit one outstanding read and one outstanding write concurrently.

Reset
REQ-020 SHALL, on resetn=0 at any time including mid-transaction, force both FSMs idle and all valid, addr_ok and data_ok outputs to 0; address/data registers 0; in-flight transactions are abandoned.
REQ-021 SHALL drive rready/bready 0 during reset and 1 from the first clock after release.

Structure
REQ-022 SHALL place FSM state encodings, AXI size encodings and ID constants in shared package cpu_axi_pkg.
REQ-023 SHALL implement as a single module; no sub-module required.

Verification
REQ-024 SHALL cover inst read 0xBFC00000, zero-wait slave -> arvalid cycle N+1, inst_data_ok cycle N+2, inst_rdata=slave word.
REQ-025 SHALL cover simultaneous inst read 0x100 and data read 0x200 -> data accepted first (arid=1), inst accepted after R_IDLE (arid=0).
REQ-026 SHALL cover data write 0x80 wstrb=0x3, then data read 0x80 while in W_RESP -> read addr_ok held 0 until bvalid, then accepted.
REQ-027 SHALL cover write with awready 3 cycles before wready -> awvalid drops after AW handshake, wvalid held, single data_data_ok on bvalid.
REQ-028 SHALL cover resetn low during R_DATA -> arvalid=0, no data_ok, next read restarts cleanly.
REQ-029 SHALL cover arready held low 5 cycles -> araddr/arid/arsize stable throughout.
